ahb_bus_arbiter: RTL and testbench



---
 rtl/ahb_arb_pkg.sv | 45 ++++
 rtl/ahb_rr_picker.sv | 32 +++
 rtl/ahb_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB round-robin bus arbiter:
// transfer/burst encodings, arbiter FSM states and the burst length decoder.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Wide enough to hold a 16-beat count.
  localparam int BEAT_W = 5;

  // Number of beats in a fixed-length burst; SINGLE and undefined-length INCR
  // report 1 so the arbiter treats them as re-arbitrable every beat.
  function automatic logic [BEAT_W-1:0] burst_beats(input hburst_e burst);
    logic [BEAT_W-1:0] beats;
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: searches req upward starting just after
// ptr, wrapping around, and reports the first requester found.
module ahb_rr_picker
  import ahb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  localparam int MW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          ptr,
  output logic [MW-1:0]          winner,
  output logic                   valid
);

  logic [MW-1:0] idx_s;
  logic          hit_s;

  // Scan the NUM_MASTERS positions after ptr; the first hit is kept.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx_s  = '0;
    hit_s  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx_s  = MW'((int'(ptr) + i) % NUM_MASTERS);
      hit_s  = !valid && req[idx_s];
      winner = hit_s ? idx_s : winner;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter. Grants are re-evaluated only at arbitration
// points (every beat of SINGLE/INCR traffic, the last address beat of a
// fixed-length burst, early burst termination, or lock release) and the
// grant is pipelined into the address-phase and data-phase owner indices.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  localparam int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_d,
  output logic                   hmastlock
);

  localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0  = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = ONE_HOT0 << DEFAULT_MASTER;

  arb_state_e             state_r, nxt_state_s;
  logic [BEAT_W-1:0]      cnt_r, nxt_cnt_s;
  logic [MW-1:0]          ptr_r, gidx_r, hmaster_r, hmaster_d_r;
  logic [NUM_MASTERS-1:0] hgrant_r;
  logic                   hmastlock_r;
  logic [MW-1:0]          win_s, pick_idx_s;
  logic                   win_valid_s;
  logic                   grant_en_s;
  logic                   owner_lock_s;
  htrans_e                trans_s;
  logic [BEAT_W-1:0]      beats_s;

  ahb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req    (hbusreq),
    .ptr    (ptr_r),
    .winner (win_s),
    .valid  (win_valid_s)
  );

  assign trans_s      = htrans_e'(htrans);
  assign beats_s      = burst_beats(hburst_e'(hburst));
  assign owner_lock_s = hlock[hmaster_r];
  // With nobody requesting the bus parks on the default master.
  assign pick_idx_s   = win_valid_s ? win_s : DEF_IDX;

  // FSM state and burst beat counter; everything holds while hready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB;
      cnt_r   <= '0;
    end else if (hready) begin
      state_r <= nxt_state_s;
      cnt_r   <= nxt_cnt_s;
    end
  end

  // Next state: lock is checked before burst length so a locked burst is
  // governed purely by hlock, not by the beat count.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    case (state_r)
      ARB: begin
        if (trans_s == HTRANS_NONSEQ && owner_lock_s) begin
          nxt_state_s = LOCKED;
          nxt_cnt_s   = 5'd0;
        end else if (trans_s == HTRANS_NONSEQ && beats_s != 5'd1) begin
          nxt_state_s = BURST;
          nxt_cnt_s   = beats_s - 5'd1;
        end else begin
          nxt_state_s = ARB;
          nxt_cnt_s   = 5'd0;
        end
      end
      BURST: begin
        if (trans_s == HTRANS_SEQ) begin
          if (cnt_r <= 5'd1) begin
            nxt_state_s = ARB;
            nxt_cnt_s   = 5'd0;
          end else begin
            nxt_state_s = BURST;
            nxt_cnt_s   = cnt_r - 5'd1;
          end
        end else if (trans_s == HTRANS_BUSY) begin
          nxt_state_s = BURST;
          nxt_cnt_s   = cnt_r;
        end else begin
          // IDLE or NONSEQ mid-burst: the master abandoned the burst.
          nxt_state_s = ARB;
          nxt_cnt_s   = 5'd0;
        end
      end
      LOCKED: begin
        if (owner_lock_s) begin
          nxt_state_s = LOCKED;
        end else begin
          nxt_state_s = ARB;
        end
        nxt_cnt_s = 5'd0;
      end
      default: begin
        nxt_state_s = ARB;
        nxt_cnt_s   = 5'd0;
      end
    endcase
  end

  // Arbitration point: every accepted edge that lands (or stays) in ARB.
  always_comb begin
    grant_en_s = 1'b0;
    case (nxt_state_s)
      ARB:     grant_en_s = hready;
      BURST:   grant_en_s = 1'b0;
      LOCKED:  grant_en_s = 1'b0;
      default: grant_en_s = 1'b0;
    endcase
  end

  // Grant, rotation pointer and owner pipeline (grant -> hmaster -> hmaster_d).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gidx_r      <= DEF_IDX;
      hgrant_r    <= DEF_GRANT;
      ptr_r       <= DEF_IDX;
      hmaster_r   <= DEF_IDX;
      hmaster_d_r <= DEF_IDX;
      hmastlock_r <= 1'b0;
    end else if (hready) begin
      if (grant_en_s) begin
        gidx_r   <= pick_idx_s;
        hgrant_r <= ONE_HOT0 << pick_idx_s;
        if (win_valid_s) begin
          ptr_r <= win_s;
        end
      end
      hmaster_r   <= gidx_r;
      hmastlock_r <= hlock[gidx_r];
      hmaster_d_r <= hmaster_r;
    end
  end

  assign hgrant    = hgrant_r;
  assign hmaster   = hmaster_r;
  assign hmaster_d = hmaster_d_r;
  assign hmastlock = hmastlock_r;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed, table-driven bench for ahb_bus_arbiter (4 masters, park on 0).
module tb_ahb_bus_arbiter;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;
  localparam logic [2:0] B_SINGLE = 3'd0;
  localparam logic [2:0] B_INCR4  = 3'd3;
  localparam logic [2:0] B_INCR8  = 3'd5;

  logic       clk;
  logic       rst_n;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_d;
  logic       hmastlock;

  int total;
  int bad;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       ml;
  } vec_t;

  vec_t vecs[30];

  ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmaster_d (hmaster_d),
    .hmastlock (hmastlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic [3:0] req, logic [3:0] lock, logic [1:0] trans,
                              logic [2:0] burst, logic rdy, logic [3:0] g,
                              logic [1:0] m, logic [1:0] md, logic ml);
    vec_t v;
    v.req = req; v.lock = lock; v.trans = trans; v.burst = burst; v.rdy = rdy;
    v.g = g; v.m = m; v.md = md; v.ml = ml;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] m,
                            input logic [1:0] md, input logic ml);
    chk({tag, " hgrant"},    32'(hgrant),    32'(g));
    chk({tag, " hmaster"},   32'(hmaster),   32'(m));
    chk({tag, " hmaster_d"}, 32'(hmaster_d), 32'(md));
    chk({tag, " hmastlock"}, 32'(hmastlock), 32'(ml));
  endtask

  task automatic run_vec(input int i);
    hbusreq = vecs[i].req;
    hlock   = vecs[i].lock;
    htrans  = vecs[i].trans;
    hburst  = vecs[i].burst;
    hready  = vecs[i].rdy;
    @(posedge clk);
    #1;
    check_outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].m, vecs[i].md, vecs[i].ml);
  endtask

  task automatic drive(input logic [3:0] req, input logic [1:0] trans, input logic [2:0] burst);
    hbusreq = req;
    hlock   = 4'b0000;
    htrans  = trans;
    hburst  = burst;
    hready  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt_w[4];
    total = 0;
    bad   = 0;

    // Idle park, then 0110 alternates between masters 1 and 2
    vecs[0]  = mk(4'b0000, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    vecs[1]  = mk(4'b0000, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    vecs[2]  = mk(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
    vecs[3]  = mk(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0);
    vecs[4]  = mk(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd2, 2'd1, 1'b0);
    vecs[5]  = mk(4'b0110, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0100, 2'd1, 2'd2, 1'b0);
    // Master 1 INCR4 with master 3 waiting, two stall cycles mid-burst
    vecs[6]  = mk(4'b0010, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0010, 2'd2, 2'd1, 1'b0);
    vecs[7]  = mk(4'b0010, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0);
    vecs[8]  = mk(4'b1010, 4'b0000, T_NONSEQ, B_INCR4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    vecs[9]  = mk(4'b1010, 4'b0000, T_SEQ,    B_INCR4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    vecs[10] = mk(4'b1010, 4'b0000, T_SEQ,    B_INCR4,  1'b0, 4'b0010, 2'd1, 2'd1, 1'b0);
    vecs[11] = mk(4'b1010, 4'b0000, T_SEQ,    B_INCR4,  1'b0, 4'b0010, 2'd1, 2'd1, 1'b0);
    vecs[12] = mk(4'b1010, 4'b0000, T_SEQ,    B_INCR4,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    vecs[13] = mk(4'b1010, 4'b0000, T_SEQ,    B_INCR4,  1'b1, 4'b1000, 2'd1, 2'd1, 1'b0);
    // Master 2 INCR8 terminated early with IDLE, master 0 waiting
    vecs[14] = mk(4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd3, 2'd1, 1'b0);
    vecs[15] = mk(4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd2, 2'd3, 1'b0);
    vecs[16] = mk(4'b0101, 4'b0000, T_NONSEQ, B_INCR8,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
    vecs[17] = mk(4'b0101, 4'b0000, T_SEQ,    B_INCR8,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
    vecs[18] = mk(4'b0101, 4'b0000, T_SEQ,    B_INCR8,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
    vecs[19] = mk(4'b0101, 4'b0000, T_IDLE,   B_INCR8,  1'b1, 4'b0001, 2'd2, 2'd2, 1'b0);
    vecs[20] = mk(4'b0101, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd0, 2'd2, 1'b0);
    // All four requesting SINGLE: strict rotation
    vecs[21] = mk(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd2, 2'd0, 1'b0);
    vecs[22] = mk(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd3, 2'd2, 1'b0);
    vecs[23] = mk(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd0, 2'd3, 1'b0);
    vecs[24] = mk(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0);
    vecs[25] = mk(4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd2, 2'd1, 1'b0);
    // Locked pair of SINGLEs by master 0 (run right after a reset)
    vecs[26] = mk(4'b0011, 4'b0001, T_NONSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1);
    vecs[27] = mk(4'b0011, 4'b0001, T_NONSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b1);
    vecs[28] = mk(4'b0011, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
    vecs[29] = mk(4'b0011, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0001, 2'd1, 2'd0, 1'b0);

    rst_n   = 1'b0;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    htrans  = T_IDLE;
    hburst  = B_SINGLE;
    hready  = 1'b1;
    #12;
    check_outs("reset", 4'b0001, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      run_vec(i);
    end

    // Eight more rotation points: every 4-edge window grants each master once
    for (int w = 0; w < 2; w++) begin
      for (int m = 0; m < 4; m++) cnt_w[m] = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        chk($sformatf("rot onehot w%0d k%0d", w, k), 32'($countones(hgrant)), 32'd1);
        for (int m = 0; m < 4; m++) begin
          if (hgrant[m]) cnt_w[m]++;
        end
      end
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("rot count w%0d m%0d", w, m), 32'(cnt_w[m]), 32'd1);
      end
    end

    // Asynchronous reset in the middle of an INCR4 burst by master 1
    drive(4'b0010, T_IDLE, B_SINGLE);
    drive(4'b0010, T_IDLE, B_SINGLE);
    drive(4'b1010, T_NONSEQ, B_INCR4);
    drive(4'b1010, T_SEQ, B_INCR4);
    check_outs("pre-reset burst", 4'b0010, 2'd1, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 4'b0001, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 26; i < 30; i++) begin
      run_vec(i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
